// File: rtl/vga_vram_pkg.sv
// Shared types and constants for the VGA video-RAM arbiter slice.
// Grant encoding, CPU command record and the saturating wait-counter helper.
package vga_vram_pkg;

  localparam int unsigned WAIT_W      = 16;
  localparam int unsigned VRAM_ADDR_W = 16;
  localparam int unsigned VRAM_DATA_W = 12;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

  // Sized for the widest supported VRAM; narrower instances zero-extend into it.
  typedef struct packed {
    logic                   we;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] wdata;
  } cpu_cmd_t;

  localparam int unsigned CMD_W = $bits(cpu_cmd_t);

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// Bundle of the video-fetch, CPU-command and RAM-port signals around the arbiter.
// The arbiter takes the slave view; requesters plus RAM take the master view.
interface vga_vram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 12
) ();

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              cpu_valid;
  logic              cpu_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output vid_req, vid_addr,
    input  vid_rvalid, vid_rdata,
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  vid_req, vid_addr,
    output vid_rvalid, vid_rdata,
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rvalid, cpu_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

endinterface

// File: rtl/vga_vram_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued CPU commands.
// Pointers carry one extra bit so full and empty are told apart on wrap.
module vga_vram_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  // A pop frees its slot only from the next cycle on, so a push at full is dropped.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign dout = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= din;
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: video fetches win every cycle, CPU commands drain from a
// FIFO in idle cycles, and read data returns two cycles after issue with a wait monitor.
module vga_vram_arbiter
  import vga_vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = VRAM_ADDR_W,
  parameter int unsigned DATA_W     = VRAM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  vga_vram_arbiter_if.slave bus,
  output logic [WAIT_W-1:0] cpu_wait_max
);

  gnt_e              gnt;
  cpu_cmd_t          push_cmd;
  cpu_cmd_t          head_cmd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              tag_vid_q;
  logic              tag_cpu_q;
  logic              vid_rvalid_q;
  logic              cpu_rvalid_q;
  logic [DATA_W-1:0] vid_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [WAIT_W-1:0] wait_ctr_q, wait_ctr_d;
  logic [WAIT_W-1:0] wait_max_q, wait_max_d;

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  always_comb begin
    push_cmd       = '0;
    push_cmd.we    = bus.cpu_we;
    push_cmd.addr  = VRAM_ADDR_W'(bus.cpu_addr);
    push_cmd.wdata = VRAM_DATA_W'(bus.cpu_wdata);
  end

  assign bus.cpu_ready = ~fifo_full;
  assign push          = bus.cpu_valid & ~fifo_full;

  vga_vram_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_cmd),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Grant and RAM port
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt = GNT_NONE;
    if (bus.vid_req) begin
      gnt = GNT_VID;
    end else if (!fifo_empty) begin
      gnt = GNT_CPU;
    end
  end

  assign pop = (gnt == GNT_CPU);

  // Idle cycles keep presenting the last address/data to avoid needless RAM toggling.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = ram_addr_q;
    bus.ram_wdata = ram_wdata_q;
    unique case (gnt)
      GNT_VID: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.vid_addr;
      end
      GNT_CPU: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = head_cmd.we;
        bus.ram_addr  = ADDR_W'(head_cmd.addr);
        bus.ram_wdata = DATA_W'(head_cmd.wdata);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Starvation monitor
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_ctr_d = wait_ctr_q;
    if (gnt == GNT_CPU) begin
      wait_ctr_d = '0;
    end else if (!fifo_empty) begin
      wait_ctr_d = sat_inc(wait_ctr_q);
    end
    wait_max_d = (wait_ctr_q > wait_max_q) ? wait_ctr_q : wait_max_q;
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline, response registers and held RAM port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      tag_vid_q    <= 1'b0;
      tag_cpu_q    <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      wait_ctr_q   <= '0;
      wait_max_q   <= '0;
    end else begin
      ram_addr_q   <= bus.ram_addr;
      ram_wdata_q  <= bus.ram_wdata;
      // Stage 1 marks reads whose data appears on ram_rdata next cycle.
      tag_vid_q    <= (gnt == GNT_VID);
      tag_cpu_q    <= (gnt == GNT_CPU) && !head_cmd.we;
      vid_rvalid_q <= tag_vid_q;
      cpu_rvalid_q <= tag_cpu_q;
      if (tag_vid_q) vid_rdata_q <= bus.ram_rdata;
      if (tag_cpu_q) cpu_rdata_q <= bus.ram_rdata;
      wait_ctr_q   <= wait_ctr_d;
      wait_max_q   <= wait_max_d;
    end
  end

  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign cpu_wait_max   = wait_max_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: per-cycle vector table plus starvation and reset runs.
// RAM is modelled here; unwritten words read back as their own address[11:0].
module tb_vga_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wait_max;

  int tests = 0;
  int fails = 0;

  vga_vram_arbiter_if #(.ADDR_W(16), .DATA_W(12)) bus ();

  vga_vram_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (12),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cpu_wait_max (wait_max)
  );

  always #5 clk = ~clk;

  logic [11:0] mem      [65536];
  bit          mem_wr   [65536];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr]    <= bus.ram_wdata;
        mem_wr[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_rdata <= mem_wr[bus.ram_addr] ? mem[bus.ram_addr] : bus.ram_addr[11:0];
      end
    end
  end

  typedef struct {
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        cpu_valid;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [11:0] wdata;
    logic        ready;
    logic        vrv;
    logic [11:0] vrd;
    logic        crv;
    logic [11:0] crd;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vec [NVEC];

  function automatic vec_t mk(
    input logic vr, input logic [15:0] va, input logic cv, input logic cw,
    input logic [15:0] ca, input logic [11:0] cd, input logic en, input logic we,
    input logic [15:0] ra, input logic [11:0] wd, input logic rdy, input logic vrv,
    input logic [11:0] vrd, input logic crv, input logic [11:0] crd);
    vec_t v;
    v.vid_req = vr;  v.vid_addr = va;  v.cpu_valid = cv;  v.cpu_we = cw;
    v.cpu_addr = ca; v.cpu_wdata = cd; v.en = en;         v.we = we;
    v.addr = ra;     v.wdata = wd;     v.ready = rdy;     v.vrv = vrv;
    v.vrd = vrd;     v.crv = crv;      v.crd = crd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_valid = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  initial begin
    int acc;
    int bad;

    // Video burst 0..9, then write/read of 0x100, then four reads interleaved with video.
    for (int n = 0; n < 10; n++) begin
      vec[n] = mk(1, 16'(n), 0, 0, 0, 0, 1, 0, 16'(n), 0, 1, (n >= 2), 12'(n - 2), 0, 0);
    end
    vec[10] = mk(0, 0,     0, 0, 0,     0,     0, 0, 16'h009, 0,     1, 1, 12'h008, 0, 0);
    vec[11] = mk(0, 0,     0, 0, 0,     0,     0, 0, 16'h009, 0,     1, 1, 12'h009, 0, 0);
    vec[12] = mk(0, 0,     1, 1, 'h100, 'hABC, 0, 0, 16'h009, 0,     1, 0, 0,       0, 0);
    vec[13] = mk(0, 0,     1, 0, 'h100, 0,     1, 1, 16'h100, 'hABC, 1, 0, 0,       0, 0);
    vec[14] = mk(0, 0,     0, 0, 0,     0,     1, 0, 16'h100, 0,     1, 0, 0,       0, 0);
    vec[15] = mk(0, 0,     0, 0, 0,     0,     0, 0, 16'h100, 0,     1, 0, 0,       0, 0);
    vec[16] = mk(0, 0,     0, 0, 0,     0,     0, 0, 16'h100, 0,     1, 0, 0,       1, 'hABC);
    vec[17] = mk(0, 0,     0, 0, 0,     0,     0, 0, 16'h100, 0,     1, 0, 0,       0, 0);
    vec[18] = mk(1, 'h20,  1, 0, 'h005, 0,     1, 0, 16'h020, 0,     1, 0, 0,       0, 0);
    vec[19] = mk(1, 'h21,  1, 0, 'h006, 0,     1, 0, 16'h021, 0,     1, 0, 0,       0, 0);
    vec[20] = mk(1, 'h22,  1, 0, 'h007, 0,     1, 0, 16'h022, 0,     1, 1, 12'h020, 0, 0);
    vec[21] = mk(1, 'h23,  1, 0, 'h008, 0,     1, 0, 16'h023, 0,     1, 1, 12'h021, 0, 0);
    vec[22] = mk(1, 'h30,  0, 0, 0,     0,     1, 0, 16'h030, 0,     0, 1, 12'h022, 0, 0);
    vec[23] = mk(0, 0,     0, 0, 0,     0,     1, 0, 16'h005, 0,     0, 1, 12'h023, 0, 0);
    vec[24] = mk(1, 'h31,  0, 0, 0,     0,     1, 0, 16'h031, 0,     1, 1, 12'h030, 0, 0);
    vec[25] = mk(0, 0,     0, 0, 0,     0,     1, 0, 16'h006, 0,     1, 0, 0,       1, 'h005);
    vec[26] = mk(1, 'h32,  0, 0, 0,     0,     1, 0, 16'h032, 0,     1, 1, 12'h031, 0, 0);
    vec[27] = mk(0, 0,     0, 0, 0,     0,     1, 0, 16'h007, 0,     1, 0, 0,       1, 'h006);
    vec[28] = mk(1, 'h33,  0, 0, 0,     0,     1, 0, 16'h033, 0,     1, 1, 12'h032, 0, 0);
    vec[29] = mk(0, 0,     0, 0, 0,     0,     1, 0, 16'h008, 0,     1, 0, 0,       1, 'h007);
    vec[30] = mk(0, 0,     0, 0, 0,     0,     0, 0, 16'h008, 0,     1, 1, 12'h033, 0, 0);
    vec[31] = mk(0, 0,     0, 0, 0,     0,     0, 0, 16'h008, 0,     1, 0, 0,       1, 'h008);
    vec[32] = mk(0, 0,     0, 0, 0,     0,     0, 0, 16'h008, 0,     1, 0, 0,       0, 0);

    // Reset and idle
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset vid_rdata",  32'(bus.vid_rdata), 0);
    check("reset cpu_rdata",  32'(bus.cpu_rdata), 0);
    check("reset ram_addr",   32'(bus.ram_addr), 0);
    check("reset ram_wdata",  32'(bus.ram_wdata), 0);
    check("reset wait_max",   32'(wait_max), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle%0d ram_en", i),     32'(bus.ram_en), 0);
      check($sformatf("idle%0d ram_we", i),     32'(bus.ram_we), 0);
      check($sformatf("idle%0d cpu_ready", i),  32'(bus.cpu_ready), 1);
      check($sformatf("idle%0d vid_rvalid", i), 32'(bus.vid_rvalid), 0);
      check($sformatf("idle%0d cpu_rvalid", i), 32'(bus.cpu_rvalid), 0);
    end

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.vid_req   = vec[i].vid_req;
      bus.vid_addr  = vec[i].vid_addr;
      bus.cpu_valid = vec[i].cpu_valid;
      bus.cpu_we    = vec[i].cpu_we;
      bus.cpu_addr  = vec[i].cpu_addr;
      bus.cpu_wdata = vec[i].cpu_wdata;
      #1;
      check($sformatf("v%0d ram_en", i),     32'(bus.ram_en),     32'(vec[i].en));
      check($sformatf("v%0d ram_we", i),     32'(bus.ram_we),     32'(vec[i].we));
      check($sformatf("v%0d ram_addr", i),   32'(bus.ram_addr),   32'(vec[i].addr));
      check($sformatf("v%0d cpu_ready", i),  32'(bus.cpu_ready),  32'(vec[i].ready));
      check($sformatf("v%0d vid_rvalid", i), 32'(bus.vid_rvalid), 32'(vec[i].vrv));
      check($sformatf("v%0d cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(vec[i].crv));
      if (vec[i].we)
        check($sformatf("v%0d ram_wdata", i), 32'(bus.ram_wdata), 32'(vec[i].wdata));
      if (vec[i].vrv)
        check($sformatf("v%0d vid_rdata", i), 32'(bus.vid_rdata), 32'(vec[i].vrd));
      if (vec[i].crv)
        check($sformatf("v%0d cpu_rdata", i), 32'(bus.cpu_rdata), 32'(vec[i].crd));
    end

    // Starvation: 20 cycles of video while the CPU offers 6 writes
    acc = 0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.vid_req   = 1'b1;
      bus.vid_addr  = 16'h0040 + 16'(c);
      bus.cpu_valid = (acc < 6);
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 16'h0200 + 16'(acc);
      bus.cpu_wdata = 12'h5A0 + 12'(acc);
      #1;
      if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0040 + 16'(c))
        bad++;
      if (bus.cpu_ready === 1'b1) acc++;
    end
    check("starve no cpu issue", 32'(bad), 0);
    check("starve accepted", 32'(acc), 4);
    check("starve cpu_ready", 32'(bus.cpu_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      check($sformatf("drain%0d ram_en", i),    32'(bus.ram_en), 1);
      check($sformatf("drain%0d ram_we", i),    32'(bus.ram_we), 1);
      check($sformatf("drain%0d ram_addr", i),  32'(bus.ram_addr), 32'(16'h0200 + 16'(i)));
      check($sformatf("drain%0d ram_wdata", i), 32'(bus.ram_wdata), 32'(12'h5A0 + 12'(i)));
    end
    @(negedge clk);
    #1;
    check("starve wait_max>=19", 32'(wait_max >= 16'd19), 1);
    check("starve fifo drained", 32'(bus.ram_en), 0);

    // Reset with 3 CPU reads queued and video reads in flight
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.vid_req   = 1'b1;
      bus.vid_addr  = 16'h0050 + 16'(c);
      bus.cpu_valid = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 16'h0300 + 16'(c);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rst%0d vid_rvalid", i), 32'(bus.vid_rvalid), 0);
      check($sformatf("rst%0d cpu_rvalid", i), 32'(bus.cpu_rvalid), 0);
      check($sformatf("rst%0d ram_en", i),     32'(bus.ram_en), 0);
      check($sformatf("rst%0d cpu_ready", i),  32'(bus.cpu_ready), 1);
      check($sformatf("rst%0d wait_max", i),   32'(wait_max), 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
